// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature step decoder: phase encodings,
// FSM states, counter widths and the phase-transition classifier.
package enc_pkg;

  // Width of the per-channel debounce counter; DEBOUNCE must fit in it.
  localparam int unsigned DB_CNT_W = 8;

  // Filtered phase encodings {a,b} in forward Gray order.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Decoder FSM states.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Classification of a prev -> cur phase pair.
  typedef enum logic [1:0] {
    TR_NONE = 2'b00,
    TR_FWD  = 2'b01,
    TR_REV  = 2'b10,
    TR_ERR  = 2'b11
  } trans_e;

  // Successor of a phase in forward order (00 -> 01 -> 11 -> 10 -> 00).
  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    logic [1:0] nxt;
    unique case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // Reverse is the inverse of forward, so prev is the forward successor of cur.
  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_e tr;
    if (cur == prev) begin
      tr = TR_NONE;
    end else if (cur == fwd_next(prev)) begin
      tr = TR_FWD;
    end else if (prev == fwd_next(cur)) begin
      tr = TR_REV;
    end else begin
      // Both bits flipped: direction cannot be determined.
      tr = TR_ERR;
    end
    return tr;
  endfunction

endpackage

// File: rtl/quad_step_decoder_debounce.sv
// debounce_bit: 2-FF synchronizer followed by a level filter that accepts a
// new level only after it has been stable for DEBOUNCE synchronized cycles.
module debounce_bit
  import enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  input  logic init_load_i,
  output logic sync_o,
  output logic filt_o
);

  // Terminal count: the filter flips on the edge the counter would reach DEBOUNCE.
  localparam logic [DB_CNT_W-1:0] CntLast = DB_CNT_W'(DEBOUNCE - 1);

  logic                sync1_q, sync2_q;
  logic                filt_q, filt_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchronizer for the asynchronous encoder channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  // Filter next state: count while levels differ, clear when they agree.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (init_load_i) begin
      // Track the synchronizer directly so RUN starts from a settled level.
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = sync2_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: debounced x4 quadrature decoder producing one-cycle step
// pulses with a held direction flag, plus an error pulse on phase jumps.
module quad_step_decoder
  import enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic       step,
  output logic       up,
  output logic       err,
  output logic [1:0] phase
);

  // INIT counter needs one extra bit since it counts up to DEBOUNCE+1.
  localparam int unsigned            InitW    = DB_CNT_W + 1;
  localparam logic [InitW-1:0] InitLast = InitW'(DEBOUNCE + 1);

  logic             sync_a, sync_b;
  logic             filt_a, filt_b;
  logic             init_load;
  logic [1:0]       cur;
  logic [1:0]       sync_ph;
  trans_e           trans;

  state_e           state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic             step_q, step_d;
  logic             up_q, up_d;
  logic             err_q, err_d;

  assign init_load = (state_q == ST_INIT);

  debounce_bit #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb_a (
    .clk_i      (clk),
    .rst_ni     (reset),
    .din_i      (enc_a),
    .init_load_i(init_load),
    .sync_o     (sync_a),
    .filt_o     (filt_a)
  );

  debounce_bit #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb_b (
    .clk_i      (clk),
    .rst_ni     (reset),
    .din_i      (enc_b),
    .init_load_i(init_load),
    .sync_o     (sync_b),
    .filt_o     (filt_b)
  );

  assign cur     = {filt_a, filt_b};
  assign sync_ph = {sync_a, sync_b};

  // FSM next state, previous-phase tracking and transition decode.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    up_d       = up_q;
    trans      = classify(prev_q, cur);
    unique case (state_q)
      ST_INIT: begin
        // prev follows the synchronizer like the filters, so no step fires on entry to RUN.
        prev_d = sync_ph;
        if (init_cnt_q == InitLast) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + InitW'(1);
        end
      end
      ST_RUN: begin
        prev_d = cur;
        unique case (trans)
          TR_FWD: begin
            step_d = 1'b1;
            up_d   = 1'b1;
          end
          TR_REV: begin
            step_d = 1'b1;
            up_d   = 1'b0;
          end
          TR_ERR:  err_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // FSM, prev register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= PH_00;
      step_q     <= 1'b0;
      up_q       <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      up_q       <= up_d;
      err_q      <= err_d;
    end
  end

  assign step  = step_q;
  assign up    = up_q;
  assign err   = err_q;
  assign phase = cur;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with DEBOUNCE = 4 (pulse 7 edges after input change).
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       step, up, err;
  logic [1:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quad_step_decoder #(
    .DEBOUNCE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .step (step),
    .up   (up),
    .err  (err),
    .phase(phase)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_step"}, 32'(step), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_up"}, 32'(up), 32'd1);
    check_eq({tag, "_phase"}, 32'(phase), 32'd0);
  endtask

  task automatic set_in(input logic [1:0] ph);
    @(negedge clk);
    enc_a = ph[1];
    enc_b = ph[0];
  endtask

  // Apply a new phase and check timing of the resulting pulse over 12 cycles.
  task automatic run_step(input logic [1:0] from, input logic [1:0] to,
                          input logic exp_step, input logic exp_err, input logic exp_up);
    set_in(to);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("step_%b%b_e%0d", from, to, i), 32'(step),
               32'((i == 7) ? exp_step : 1'b0));
      check_eq($sformatf("err_%b%b_e%0d", from, to, i), 32'(err),
               32'((i == 7) ? exp_err : 1'b0));
      if (i == 5) check_eq("phase_old", 32'(phase), 32'(from));
      if (i == 6) check_eq("phase_new", 32'(phase), 32'(to));
      if (i >= 7) check_eq("up", 32'(up), 32'(exp_up));
    end
  endtask

  // n cycles with no pulses allowed; phase checked at the end.
  task automatic quiet(input int n, input logic [1:0] exp_ph, input string tag);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_step"}, 32'(step), 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
    end
    check_eq({tag, "_phase"}, 32'(phase), 32'(exp_ph));
  endtask

  initial begin
    #12;
    check_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b1;
    quiet(10, 2'b00, "init");
    check_eq("init_up", 32'(up), 32'd1);

    // Forward rotation.
    run_step(2'b00, 2'b01, 1'b1, 1'b0, 1'b1);
    run_step(2'b01, 2'b11, 1'b1, 1'b0, 1'b1);
    run_step(2'b11, 2'b10, 1'b1, 1'b0, 1'b1);
    run_step(2'b10, 2'b00, 1'b1, 1'b0, 1'b1);

    // Reverse rotation.
    run_step(2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
    run_step(2'b10, 2'b11, 1'b1, 1'b0, 1'b0);
    run_step(2'b11, 2'b01, 1'b1, 1'b0, 1'b0);
    run_step(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    quiet(5, 2'b00, "rev_hold");
    check_eq("rev_up_held", 32'(up), 32'd0);

    // 3-cycle glitch on A is rejected.
    @(negedge clk);
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    quiet(12, 2'b00, "glitch");
    check_eq("glitch_up", 32'(up), 32'd0);

    // Both channels at once -> err, up unchanged.
    run_step(2'b00, 2'b11, 1'b0, 1'b1, 1'b0);

    // Reset while holding 11: no pulses through INIT, phase settles to 11.
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_vals("rst11");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      check_eq("init11_step", 32'(step), 32'd0);
      check_eq("init11_err", 32'(err), 32'd0);
      if (i == 6) check_eq("init11_phase", 32'(phase), 32'd3);
    end

    run_step(2'b11, 2'b10, 1'b1, 1'b0, 1'b1);
    run_step(2'b10, 2'b00, 1'b1, 1'b0, 1'b1);

    // Reset mid-debounce of 00 -> 01.
    set_in(2'b01);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_vals("rst_mid_db");
    @(negedge clk);
    reset = 1'b1;
    quiet(12, 2'b01, "post_db");

    // Reset during a step pulse (01 -> 00 reverse).
    set_in(2'b00);
    repeat (7) @(posedge clk);
    #1;
    check_eq("pulse_step", 32'(step), 32'd1);
    check_eq("pulse_up", 32'(up), 32'd0);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_mid_pulse");
    @(negedge clk);
    reset = 1'b1;
    quiet(12, 2'b00, "post_pulse");
    check_eq("post_pulse_up", 32'(up), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
